// File: rtl/axi_decerr_responder.sv
// Default AXI slave: completes unmapped-address transactions with DECERR.
// Ports: AXI AW/W/B/AR/R channels plus a saturating DECERR_COUNT output.
module axi_decerr_responder #(
    parameter int id_bits   = 4,
    parameter int data_bits = 32,
    parameter int cnt_bits  = 16
) (
    input  logic                 ACLK,
    input  logic                 ARESETn,
    input  logic                 AWVALID,
    output logic                 AWREADY,
    input  logic [id_bits-1:0]   AWID,
    input  logic [7:0]           AWLEN,
    input  logic                 WVALID,
    output logic                 WREADY,
    input  logic [data_bits-1:0] WDATA,
    input  logic                 WLAST,
    output logic                 BVALID,
    input  logic                 BREADY,
    output logic [id_bits-1:0]   BID,
    output logic [1:0]           BRESP,
    input  logic                 ARVALID,
    output logic                 ARREADY,
    input  logic [id_bits-1:0]   ARID,
    input  logic [7:0]           ARLEN,
    output logic                 RVALID,
    input  logic                 RREADY,
    output logic [id_bits-1:0]   RID,
    output logic [data_bits-1:0] RDATA,
    output logic [1:0]           RRESP,
    output logic                 RLAST,
    output logic [cnt_bits-1:0]  DECERR_COUNT
);

    localparam logic [1:0] DECERR = 2'b11;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } w_state_e;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } r_state_e;

    // Write data and burst length carry no meaning for an error response.
    logic unused_inputs;
    assign unused_inputs = ^{WDATA, AWLEN};

    w_state_e                w_state_q, w_state_d;
    logic                    aw_ready_q, aw_ready_d;
    logic                    w_ready_q, w_ready_d;
    logic                    b_valid_q, b_valid_d;
    logic [id_bits-1:0]      aw_id_q, aw_id_d;
    logic [id_bits-1:0]      b_id_q, b_id_d;
    logic [1:0]              b_resp_q, b_resp_d;

    r_state_e                r_state_q, r_state_d;
    logic                    ar_ready_q, ar_ready_d;
    logic                    r_valid_q, r_valid_d;
    logic                    r_last_q, r_last_d;
    logic [id_bits-1:0]      r_id_q, r_id_d;
    logic [1:0]              r_resp_q, r_resp_d;
    logic [7:0]              r_cnt_q, r_cnt_d;

    logic [cnt_bits-1:0]     cnt_q, cnt_d;
    logic [cnt_bits:0]       cnt_sum;
    logic                    b_hs;
    logic                    r_done;

    assign b_hs   = b_valid_q & BREADY;
    assign r_done = r_valid_q & RREADY & r_last_q;

    always_comb begin
        w_state_d  = w_state_q;
        aw_ready_d = aw_ready_q;
        w_ready_d  = w_ready_q;
        b_valid_d  = b_valid_q;
        aw_id_d    = aw_id_q;
        b_id_d     = b_id_q;
        b_resp_d   = b_resp_q;
        case (w_state_q)
            W_IDLE: begin
                if (AWVALID && aw_ready_q) begin
                    aw_id_d    = AWID;
                    aw_ready_d = 1'b0;
                    w_ready_d  = 1'b1;
                    w_state_d  = W_DATA;
                end
            end
            W_DATA: begin
                // Only WLAST ends the burst; AWLEN is deliberately ignored.
                if (WVALID && w_ready_q && WLAST) begin
                    w_ready_d = 1'b0;
                    b_valid_d = 1'b1;
                    b_id_d    = aw_id_q;
                    b_resp_d  = DECERR;
                    w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (b_hs) begin
                    b_valid_d  = 1'b0;
                    aw_ready_d = 1'b1;
                    w_state_d  = W_IDLE;
                end
            end
            default: begin
                w_state_d  = W_IDLE;
                aw_ready_d = 1'b1;
                w_ready_d  = 1'b0;
                b_valid_d  = 1'b0;
            end
        endcase
    end

    always_comb begin
        r_state_d  = r_state_q;
        ar_ready_d = ar_ready_q;
        r_valid_d  = r_valid_q;
        r_last_d   = r_last_q;
        r_id_d     = r_id_q;
        r_resp_d   = r_resp_q;
        r_cnt_d    = r_cnt_q;
        case (r_state_q)
            R_IDLE: begin
                if (ARVALID && ar_ready_q) begin
                    r_cnt_d    = ARLEN;
                    ar_ready_d = 1'b0;
                    r_valid_d  = 1'b1;
                    r_id_d     = ARID;
                    r_resp_d   = DECERR;
                    r_last_d   = (ARLEN == 8'd0);
                    r_state_d  = R_DATA;
                end
            end
            R_DATA: begin
                if (r_valid_q && RREADY) begin
                    if (r_last_q) begin
                        r_valid_d  = 1'b0;
                        r_last_d   = 1'b0;
                        ar_ready_d = 1'b1;
                        r_state_d  = R_IDLE;
                    end else begin
                        // Counter is >= 1 here, so it never wraps.
                        r_cnt_d  = r_cnt_q - 8'd1;
                        r_last_d = (r_cnt_q == 8'd1);
                    end
                end
            end
            default: begin
                r_state_d  = R_IDLE;
                ar_ready_d = 1'b1;
                r_valid_d  = 1'b0;
                r_last_d   = 1'b0;
            end
        endcase
    end

    // One extra bit catches overflow so the count can clamp at all-ones.
    always_comb begin
        cnt_sum = {1'b0, cnt_q}
                + (cnt_bits+1)'(b_hs)
                + (cnt_bits+1)'(r_done);
        if (cnt_sum[cnt_bits]) begin
            cnt_d = '1;
        end else begin
            cnt_d = cnt_sum[cnt_bits-1:0];
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            w_state_q  <= W_IDLE;
            aw_ready_q <= 1'b1;
            w_ready_q  <= 1'b0;
            b_valid_q  <= 1'b0;
            aw_id_q    <= '0;
            b_id_q     <= '0;
            b_resp_q   <= 2'b00;
            r_state_q  <= R_IDLE;
            ar_ready_q <= 1'b1;
            r_valid_q  <= 1'b0;
            r_last_q   <= 1'b0;
            r_id_q     <= '0;
            r_resp_q   <= 2'b00;
            r_cnt_q    <= 8'd0;
            cnt_q      <= '0;
        end else begin
            w_state_q  <= w_state_d;
            aw_ready_q <= aw_ready_d;
            w_ready_q  <= w_ready_d;
            b_valid_q  <= b_valid_d;
            aw_id_q    <= aw_id_d;
            b_id_q     <= b_id_d;
            b_resp_q   <= b_resp_d;
            r_state_q  <= r_state_d;
            ar_ready_q <= ar_ready_d;
            r_valid_q  <= r_valid_d;
            r_last_q   <= r_last_d;
            r_id_q     <= r_id_d;
            r_resp_q   <= r_resp_d;
            r_cnt_q    <= r_cnt_d;
            cnt_q      <= cnt_d;
        end
    end

    assign AWREADY      = aw_ready_q;
    assign WREADY       = w_ready_q;
    assign BVALID       = b_valid_q;
    assign BID          = b_id_q;
    assign BRESP        = b_resp_q;
    assign ARREADY      = ar_ready_q;
    assign RVALID       = r_valid_q;
    assign RID          = r_id_q;
    assign RDATA        = '0;
    assign RRESP        = r_resp_q;
    assign RLAST        = r_last_q;
    assign DECERR_COUNT = cnt_q;

endmodule

// File: tb/tb_axi_decerr_responder.sv
// Directed bench for axi_decerr_responder.
// A second instance with a 2-bit counter shares stimulus for saturation.
module tb_axi_decerr_responder;

    logic        ACLK = 1'b0;
    logic        ARESETn = 1'b0;
    logic        AWVALID = 1'b0;
    logic [3:0]  AWID = '0;
    logic [7:0]  AWLEN = '0;
    logic        WVALID = 1'b0;
    logic [31:0] WDATA = '0;
    logic        WLAST = 1'b0;
    logic        BREADY = 1'b0;
    logic        ARVALID = 1'b0;
    logic [3:0]  ARID = '0;
    logic [7:0]  ARLEN = '0;
    logic        RREADY = 1'b0;

    logic        AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST;
    logic [3:0]  BID, RID;
    logic [1:0]  BRESP, RRESP;
    logic [31:0] RDATA;
    logic [15:0] DECERR_COUNT;

    logic        s_awready, s_wready, s_bvalid, s_arready;
    logic        s_rvalid, s_rlast;
    logic [3:0]  s_bid, s_rid;
    logic [1:0]  s_bresp, s_rresp;
    logic [31:0] s_rdata;
    logic [1:0]  s_count;

    int total = 0;
    int bad = 0;

    always #5 ACLK = ~ACLK;

    axi_decerr_responder dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .AWID(AWID), .AWLEN(AWLEN),
        .WVALID(WVALID), .WREADY(WREADY),
        .WDATA(WDATA), .WLAST(WLAST),
        .BVALID(BVALID), .BREADY(BREADY),
        .BID(BID), .BRESP(BRESP),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .ARID(ARID), .ARLEN(ARLEN),
        .RVALID(RVALID), .RREADY(RREADY),
        .RID(RID), .RDATA(RDATA),
        .RRESP(RRESP), .RLAST(RLAST),
        .DECERR_COUNT(DECERR_COUNT)
    );

    axi_decerr_responder #(.cnt_bits(2)) dut_sat (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .AWVALID(AWVALID), .AWREADY(s_awready),
        .AWID(AWID), .AWLEN(AWLEN),
        .WVALID(WVALID), .WREADY(s_wready),
        .WDATA(WDATA), .WLAST(WLAST),
        .BVALID(s_bvalid), .BREADY(BREADY),
        .BID(s_bid), .BRESP(s_bresp),
        .ARVALID(ARVALID), .ARREADY(s_arready),
        .ARID(ARID), .ARLEN(ARLEN),
        .RVALID(s_rvalid), .RREADY(RREADY),
        .RID(s_rid), .RDATA(s_rdata),
        .RRESP(s_rresp), .RLAST(s_rlast),
        .DECERR_COUNT(s_count)
    );

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic test_reset();
        ARESETn = 1'b0;
        tick();
        tick();
        total++;
        if ({AWREADY, ARREADY, WREADY, BVALID, RVALID, RLAST}
            !== 6'b110000) begin
            bad++;
            $display("FAIL reset_ctrl got=%b exp=110000",
                     {AWREADY, ARREADY, WREADY, BVALID, RVALID, RLAST});
        end
        total++;
        if ({BID, RID, BRESP, RRESP} !== 12'd0 || RDATA !== 32'd0) begin
            bad++;
            $display("FAIL reset_data got=%h/%h exp=0/0",
                     {BID, RID, BRESP, RRESP}, RDATA);
        end
        total++;
        if (DECERR_COUNT !== 16'd0) begin
            bad++;
            $display("FAIL reset_count got=%0d exp=0", DECERR_COUNT);
        end
        ARESETn = 1'b1;
        tick();
    endtask

    task automatic test_single_write();
        AWVALID = 1'b1;
        AWID = 4'd3;
        AWLEN = 8'd0;
        BREADY = 1'b1;
        tick();
        AWVALID = 1'b0;
        total++;
        if ({AWREADY, WREADY, BVALID} !== 3'b010) begin
            bad++;
            $display("FAIL wr_after_aw got=%b exp=010",
                     {AWREADY, WREADY, BVALID});
        end
        WVALID = 1'b1;
        WLAST = 1'b1;
        WDATA = 32'hdeadbeef;
        tick();
        WVALID = 1'b0;
        WLAST = 1'b0;
        total++;
        if (BVALID !== 1'b1 || BID !== 4'd3 || BRESP !== 2'b11
            || WREADY !== 1'b0) begin
            bad++;
            $display("FAIL wr_bresp got=v%b id%0d r%b wr%b exp=v1 id3 r11 wr0",
                     BVALID, BID, BRESP, WREADY);
        end
        tick();
        BREADY = 1'b0;
        total++;
        if (BVALID !== 1'b0 || AWREADY !== 1'b1
            || DECERR_COUNT !== 16'd1) begin
            bad++;
            $display("FAIL wr_done got=v%b awr%b cnt%0d exp=v0 awr1 cnt1",
                     BVALID, AWREADY, DECERR_COUNT);
        end
    endtask

    task automatic test_read_burst();
        ARVALID = 1'b1;
        ARID = 4'd5;
        ARLEN = 8'd3;
        RREADY = 1'b1;
        tick();
        ARVALID = 1'b0;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (RVALID !== 1'b1 || RID !== 4'd5 || RRESP !== 2'b11
                || RDATA !== 32'd0 || RLAST !== (i == 3)
                || ARREADY !== 1'b0) begin
                bad++;
                $display("FAIL rd_beat%0d got=v%b id%0d r%b d%h l%b a%b",
                         i, RVALID, RID, RRESP, RDATA, RLAST, ARREADY);
            end
            tick();
        end
        RREADY = 1'b0;
        total++;
        if (RVALID !== 1'b0 || ARREADY !== 1'b1
            || DECERR_COUNT !== 16'd2) begin
            bad++;
            $display("FAIL rd_done got=v%b ar%b cnt%0d exp=v0 ar1 cnt2",
                     RVALID, ARREADY, DECERR_COUNT);
        end
    endtask

    task automatic test_backpressure();
        ARVALID = 1'b1;
        ARID = 4'd9;
        ARLEN = 8'd1;
        RREADY = 1'b0;
        tick();
        ARVALID = 1'b0;
        for (int i = 0; i < 2; i++) begin
            total++;
            if ({RVALID, RLAST} !== 2'b10 || RID !== 4'd9) begin
                bad++;
                $display("FAIL bp_stall0_%0d got=v%b l%b id%0d exp=v1 l0 id9",
                         i, RVALID, RLAST, RID);
            end
            tick();
        end
        RREADY = 1'b1;
        tick();
        RREADY = 1'b0;
        for (int i = 0; i < 2; i++) begin
            total++;
            if ({RVALID, RLAST} !== 2'b11 || RID !== 4'd9) begin
                bad++;
                $display("FAIL bp_stall1_%0d got=v%b l%b id%0d exp=v1 l1 id9",
                         i, RVALID, RLAST, RID);
            end
            tick();
        end
        RREADY = 1'b1;
        tick();
        tick();
        RREADY = 1'b0;
        total++;
        if (RVALID !== 1'b0 || DECERR_COUNT !== 16'd3) begin
            bad++;
            $display("FAIL bp_rd_done got=v%b cnt%0d exp=v0 cnt3",
                     RVALID, DECERR_COUNT);
        end
        AWVALID = 1'b1;
        AWID = 4'd7;
        tick();
        AWVALID = 1'b0;
        WVALID = 1'b1;
        WLAST = 1'b1;
        tick();
        WVALID = 1'b0;
        WLAST = 1'b0;
        for (int i = 0; i < 5; i++) begin
            total++;
            if (BVALID !== 1'b1 || BID !== 4'd7 || BRESP !== 2'b11) begin
                bad++;
                $display("FAIL bp_bhold%0d got=v%b id%0d r%b exp=v1 id7 r11",
                         i, BVALID, BID, BRESP);
            end
            tick();
        end
        BREADY = 1'b1;
        tick();
        BREADY = 1'b0;
        total++;
        if (BVALID !== 1'b0 || DECERR_COUNT !== 16'd4) begin
            bad++;
            $display("FAIL bp_wr_done got=v%b cnt%0d exp=v0 cnt4",
                     BVALID, DECERR_COUNT);
        end
    endtask

    task automatic test_concurrent();
        AWVALID = 1'b1;
        AWID = 4'd2;
        AWLEN = 8'd3;
        ARVALID = 1'b1;
        ARID = 4'd4;
        ARLEN = 8'd0;
        tick();
        AWVALID = 1'b0;
        ARVALID = 1'b0;
        for (int i = 0; i < 4; i++) begin
            WVALID = 1'b1;
            WLAST = (i == 3);
            tick();
        end
        WVALID = 1'b0;
        WLAST = 1'b0;
        total++;
        if ({BVALID, RVALID, RLAST} !== 3'b111 || BID !== 4'd2
            || RID !== 4'd4 || DECERR_COUNT !== 16'd4) begin
            bad++;
            $display("FAIL cc_pending got=%b b%0d r%0d cnt%0d exp=111 b2 r4 cnt4",
                     {BVALID, RVALID, RLAST}, BID, RID, DECERR_COUNT);
        end
        BREADY = 1'b1;
        RREADY = 1'b1;
        tick();
        BREADY = 1'b0;
        RREADY = 1'b0;
        total++;
        if (BVALID !== 1'b0 || RVALID !== 1'b0
            || DECERR_COUNT !== 16'd6) begin
            bad++;
            $display("FAIL cc_dual got=b%b r%b cnt%0d exp=b0 r0 cnt6",
                     BVALID, RVALID, DECERR_COUNT);
        end
    endtask

    task automatic test_reset_mid_read();
        ARVALID = 1'b1;
        ARID = 4'd1;
        ARLEN = 8'd7;
        RREADY = 1'b1;
        tick();
        ARVALID = 1'b0;
        tick();
        #2;
        ARESETn = 1'b0;
        #1;
        total++;
        if (RVALID !== 1'b0 || ARREADY !== 1'b1
            || DECERR_COUNT !== 16'd0) begin
            bad++;
            $display("FAIL rst_async got=v%b ar%b cnt%0d exp=v0 ar1 cnt0",
                     RVALID, ARREADY, DECERR_COUNT);
        end
        #3;
        ARESETn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (RVALID !== 1'b0 || ARREADY !== 1'b1
                || DECERR_COUNT !== 16'd0) begin
                bad++;
                $display("FAIL rst_after%0d got=v%b ar%b cnt%0d exp=v0 ar1 cnt0",
                         i, RVALID, ARREADY, DECERR_COUNT);
            end
        end
        RREADY = 1'b0;
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 5; i++) begin
            AWVALID = 1'b1;
            AWID = 4'(i);
            tick();
            AWVALID = 1'b0;
            WVALID = 1'b1;
            WLAST = 1'b1;
            tick();
            WVALID = 1'b0;
            WLAST = 1'b0;
            BREADY = 1'b1;
            tick();
            BREADY = 1'b0;
            if (i == 1) begin
                total++;
                if (s_count !== 2'd2) begin
                    bad++;
                    $display("FAIL sat_two got=%0d exp=2", s_count);
                end
            end
        end
        total++;
        if (s_count !== 2'd3) begin
            bad++;
            $display("FAIL sat_clamp got=%0d exp=3", s_count);
        end
        total++;
        if (DECERR_COUNT !== 16'd5) begin
            bad++;
            $display("FAIL sat_wide got=%0d exp=5", DECERR_COUNT);
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_read_burst();
        test_backpressure();
        test_concurrent();
        test_reset_mid_read();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axi_decerr_responder.md
Name: axi_decerr_responder

Overview:
- Default AXI slave that completes every transaction the segment address decoder maps to no slave, i.e. when the decoder's select error is active.
- Accepts the address and all write data beats, then returns DECERR responses so masters never hang on unmapped addresses.
- Read and write channels are independent.
- Also provides a saturating count of errored transactions for debug and status visibility.

Parameters:
- id_bits, 4, width of AWID/BID/ARID/RID
- data_bits, 32, width of WDATA/RDATA
- cnt_bits, 16, width of DECERR_COUNT

Ports:
- ACLK  input  1  clock, rising edge
- ARESETn  input  1  asynchronous active-low reset
- AWVALID / AWREADY  input / output  1 / 1  write address handshake
- AWID  input  id_bits  write transaction ID
- AWLEN  input  8  write burst length minus one
- WVALID / WREADY  input / output  1 / 1  write data handshake
- WDATA  input  data_bits  ignored
- WLAST  input  1  last write beat
- BVALID / BREADY  output / input  1 / 1  write response handshake
- BID  output  id_bits  echoed AWID
- BRESP  output  2  write response
- ARVALID / ARREADY  input / output  1 / 1  read address handshake
- ARID  input  id_bits  read transaction ID
- ARLEN  input  8  read burst length minus one
- RVALID / RREADY  output / input  1 / 1  read data handshake
- RID  output  id_bits  echoed ARID
- RDATA  output  data_bits  read data
- RRESP  output  2  read response
- RLAST  output  1  last read beat
- DECERR_COUNT  output  cnt_bits  completed errored transactions

Behaviour:
- All outputs are registered.
- Reset (ARESETn low, asynchronous) drives:
  - AWREADY=1, ARREADY=1
  - WREADY=0, BVALID=0, RVALID=0, RLAST=0
  - BID=0, RID=0, BRESP=0, RRESP=0, RDATA=0
  - DECERR_COUNT=0
  - both FSMs to IDLE
- Reset asserted mid-burst abandons the transaction; no response is issued after reset.
- Write FSM states: W_IDLE, W_DATA, W_RESP.
  - W_IDLE: AWREADY=1. On AWVALID&AWREADY, latch AWID, set AWREADY=0 and WREADY=1 next cycle, go to W_DATA.
  - W_DATA: each WVALID&WREADY beat is consumed and discarded.
  - On a beat with WLAST=1: WREADY=0, BVALID=1, BID=latched ID, BRESP=2'b11, go to W_RESP.
  - Burst termination is governed by WLAST only; AWLEN is not checked.
  - W_RESP: hold BVALID/BID/BRESP stable until BREADY. On BVALID&BREADY: BVALID=0, AWREADY=1, go to W_IDLE.
  - Minimum latency: AW accepted in cycle N, single beat accepted in N+1, BVALID in N+2.
- Read FSM states: R_IDLE, R_DATA.
  - R_IDLE: ARREADY=1. On ARVALID&ARREADY:
    - latch ARID and load beat counter with ARLEN
    - next cycle: ARREADY=0, RVALID=1, RID=ARID, RDATA=0, RRESP=2'b11
    - RLAST=1 if ARLEN==0
    - go to R_DATA.
  - R_DATA: RVALID stays high. Each RVALID&RREADY decrements the counter; RLAST=1 when the counter reaches 0.
  - On a handshake with RLAST=1: RVALID=0, RLAST=0, ARREADY=1, go to R_IDLE.
  - Exactly ARLEN+1 beats are returned.
  - RID/RDATA/RRESP/RLAST stay stable while RVALID&!RREADY.
  - ARLEN=255 yields 256 beats; the counter is 8 bits and never wraps below 0.
- DECERR_COUNT:
  - +1 on each B handshake and +1 on each final R handshake (RLAST).
  - Simultaneous B and final R in the same cycle: +2.
  - Saturates at all-ones and never wraps.
- Write and read FSMs run concurrently with no interaction except the shared counter.
- Only one outstanding transaction per direction. AWVALID/ARVALID arriving while busy wait, since AWREADY/ARREADY are low.

Test Plan:
- Reset, then single write: AWID=3, AWLEN=0, one beat WLAST=1, BREADY=1 -> BVALID two cycles after AW handshake, BID=3, BRESP=2'b11, DECERR_COUNT=1.
- Read burst: ARID=5, ARLEN=3, RREADY=1 -> 4 beats with RID=5, RRESP=2'b11, RDATA=0, RLAST only on 4th beat, ARREADY high the cycle after.
- Backpressure: ARLEN=1, RREADY toggling 0/1 -> RVALID/RID/RLAST stable while stalled, exactly 2 beats delivered; BREADY held low 5 cycles -> BVALID/BID/BRESP held stable.
- Concurrent write (4 beats) and read (ARLEN=0) with B and final R handshaking in the same cycle -> DECERR_COUNT increments by 2.
- ARESETn pulsed low during a read beat 2 of 8 -> RVALID=0 immediately, ARREADY=1 after release, DECERR_COUNT=0, no further R beats.
- Saturation with cnt_bits=2: 5 completed transactions -> DECERR_COUNT reads 3.
